// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared arbiter state encoding and RAM lane count.
// Imported by the interface, the top-level arbiter and the read pipeline.
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE, CPU, DRAIN, DBG} arb_state_t;
  localparam int RAM_BE_W = 4;
endpackage

// File: rtl/ram_port_arb_if.sv
// ram_port_arb_if: bundles the CPU, loader and RAM-side signals of the arbiter.
// slave  - arbiter view: requester and RAM read data in, grants/RAM controls out.
// master - environment view: drives requests and RAM read data, observes the rest.
interface ram_port_arb_if #(parameter int XLEN = 32);
  import ram_arb_pkg::*;
  logic                cpu_rst_n_i;
  logic                cpu_req_i;
  logic                cpu_we_i;
  logic [XLEN-1:0]     cpu_addr_i;
  logic [RAM_BE_W-1:0] cpu_be_i;
  logic [XLEN-1:0]     cpu_wdata_i;
  logic                cpu_gnt_o;
  logic                cpu_rvalid_o;
  logic [XLEN-1:0]     cpu_rdata_o;
  logic                dbg_sel_i;
  logic [XLEN-1:0]     dbg_addr_i;
  logic [RAM_BE_W-1:0] dbg_wr_byte_en_i;
  logic [7:0]          dbg_wr_data_i;
  logic                dbg_gnt_o;
  logic [7:0]          dbg_rd_data_o;
  logic [XLEN-1:0]     ram_addr_o;
  logic [RAM_BE_W-1:0] ram_wr_en_o;
  logic [XLEN-1:0]     ram_wr_data_o;
  logic [XLEN-1:0]     ram_rd_data_i;
  modport slave (
    input  cpu_rst_n_i, cpu_req_i, cpu_we_i, cpu_addr_i, cpu_be_i, cpu_wdata_i,
    input  dbg_sel_i, dbg_addr_i, dbg_wr_byte_en_i, dbg_wr_data_i, ram_rd_data_i,
    output cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o, dbg_gnt_o, dbg_rd_data_o,
    output ram_addr_o, ram_wr_en_o, ram_wr_data_o
  );
  modport master (
    output cpu_rst_n_i, cpu_req_i, cpu_we_i, cpu_addr_i, cpu_be_i, cpu_wdata_i,
    output dbg_sel_i, dbg_addr_i, dbg_wr_byte_en_i, dbg_wr_data_i, ram_rd_data_i,
    input  cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o, dbg_gnt_o, dbg_rd_data_o,
    input  ram_addr_o, ram_wr_en_o, ram_wr_data_o
  );
endinterface

// File: rtl/ram_port_arb_rd_pipe.sv
// rd_pipe: RD_LAT-stage read tracker aligning RAM read data with its requester.
// push_i/own_dbg_i/lane_i enter stage 0; vld_o/own_dbg_o/lane_o leave the last
// stage; flush_i drops all in-flight CPU reads; cnt_o counts in-flight CPU reads.
module rd_pipe #(parameter int RD_LAT = 1) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         own_dbg_i,
  input  logic [1:0]                   lane_i,
  output logic                         vld_o,
  output logic                         own_dbg_o,
  output logic [1:0]                   lane_o,
  output logic [$clog2(RD_LAT+1)-1:0]  cnt_o
);
  localparam int CW = $clog2(RD_LAT+1);
  logic [RD_LAT-1:0]      vld_q, vld_d, own_q, own_d;
  logic [RD_LAT-1:0][1:0] lane_q, lane_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  always_comb begin
    vld_d[0]  = push_i & ~flush_i;
    own_d[0]  = own_dbg_i;
    lane_d[0] = lane_i;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1] & ~flush_i;
      own_d[i]  = own_q[i-1];
      lane_d[i] = lane_q[i-1];
    end
    // occupancy holds at most RD_LAT entries, so the counter cannot wrap
    cnt_d = flush_i ? '0 : cnt_q + CW'(push_i) - CW'(vld_q[RD_LAT-1]);
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q  <= '0;
      own_q  <= '0;
      lane_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      own_q  <= own_d;
      lane_q <= lane_d;
      cnt_q  <= cnt_d;
    end
  end
  assign vld_o     = vld_q[RD_LAT-1];
  assign own_dbg_o = own_q[RD_LAT-1];
  assign lane_o    = lane_q[RD_LAT-1];
  assign cnt_o     = cnt_q;
endmodule

// File: rtl/ram_port_arb.sv
// ram_port_arb: shares one byte-enabled RAM port between the CPU and the debug loader.
// clk_i/rst_n_i - clock and asynchronous active-low reset.
// bus           - CPU request/grant/read-data, loader select/grant/read-byte and
//                 RAM address/write-enable/write-data/read-data.
module ram_port_arb import ram_arb_pkg::*; #(
  parameter int XLEN   = 32,
  parameter int RD_LAT = 1
) (
  input logic           clk_i,
  input logic           rst_n_i,
  ram_port_arb_if.slave bus
);
  arb_state_t                   st_q;
  logic                         cpu_gnt, dbg_own, empty, t_vld, t_own;
  logic [1:0]                   t_lane;
  logic [$clog2(RD_LAT+1)-1:0]  cnt;
  logic                         unused_addr_lsb;
  assign unused_addr_lsb = ^bus.cpu_addr_i[1:0];
  assign dbg_own = st_q == DBG;
  assign cpu_gnt = st_q == CPU && bus.cpu_req_i && !bus.dbg_sel_i && bus.cpu_rst_n_i;
  assign empty   = cnt == '0;
  rd_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .flush_i   (!bus.cpu_rst_n_i),
    .push_i    (cpu_gnt && !bus.cpu_we_i),
    .own_dbg_i (dbg_own),
    .lane_i    (bus.dbg_addr_i[1:0]),
    .vld_o     (t_vld),
    .own_dbg_o (t_own),
    .lane_o    (t_lane),
    .cnt_o     (cnt)
  );
  // a handover goes through DRAIN so CPU reads never return on the loader's cycles
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) st_q <= IDLE;
    else begin
      case (st_q)
        IDLE:  st_q <= bus.dbg_sel_i ? DBG : (bus.cpu_req_i && bus.cpu_rst_n_i) ? CPU : IDLE;
        CPU:   st_q <= !bus.cpu_rst_n_i ? (bus.dbg_sel_i ? DBG : IDLE) :
                       bus.dbg_sel_i ? DRAIN : (!bus.cpu_req_i && empty) ? IDLE : CPU;
        DRAIN: st_q <= !bus.cpu_rst_n_i ? (bus.dbg_sel_i ? DBG : IDLE) :
                       !empty ? DRAIN : bus.dbg_sel_i ? DBG : IDLE;
        DBG:   st_q <= bus.dbg_sel_i ? DBG : IDLE;
      endcase
    end
  end
  assign bus.cpu_gnt_o     = cpu_gnt;
  assign bus.dbg_gnt_o     = dbg_own;
  assign bus.ram_addr_o    = dbg_own ? {bus.dbg_addr_i[XLEN-1:2], 2'b00} :
                             cpu_gnt ? {bus.cpu_addr_i[XLEN-1:2], 2'b00} : '0;
  assign bus.ram_wr_en_o   = dbg_own ? bus.dbg_wr_byte_en_i :
                             (cpu_gnt && bus.cpu_we_i) ? bus.cpu_be_i : '0;
  assign bus.ram_wr_data_o = dbg_own ? {RAM_BE_W{bus.dbg_wr_data_i}} :
                             cpu_gnt ? bus.cpu_wdata_i : '0;
  assign bus.cpu_rvalid_o  = t_vld;
  assign bus.cpu_rdata_o   = t_vld ? bus.ram_rd_data_i : '0;
  assign bus.dbg_rd_data_o = t_own ? bus.ram_rd_data_i[{t_lane, 3'b000} +: 8] : '0;
endmodule

// File: tb/tb_ram_port_arb.sv
// tb_ram_port_arb: directed scoreboard bench for ram_port_arb at RD_LAT=1 and RD_LAT=2.
module tb_ram_port_arb;
  import ram_arb_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  logic [31:0] r1, r2a, r2b;

  ram_port_arb_if #(.XLEN(32)) if1 ();
  ram_port_arb_if #(.XLEN(32)) if2 ();
  ram_port_arb #(.XLEN(32), .RD_LAT(1)) dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(if1));
  ram_port_arb #(.XLEN(32), .RD_LAT(2)) dut2 (.clk_i(clk), .rst_n_i(rst_n), .bus(if2));

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    case (i)
      4:       return 32'hDEADBEEF;
      5:       return 32'h01234567;
      7:       return 32'h0BADC0DE;
      8:       return 32'hCAFEF00D;
      64:      return 32'h11223344;
      default: return {16'h5A5A, i[15:0]};
    endcase
  endfunction

  // RAM macro models: byte-write, read data 1 (mem1) or 2 (mem2) cycles after address
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= init_val(i);
        mem2[i] <= init_val(i);
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (if1.ram_wr_en_o[b]) mem1[if1.ram_addr_o[9:2]][8*b +: 8] <= if1.ram_wr_data_o[8*b +: 8];
        if (if2.ram_wr_en_o[b]) mem2[if2.ram_addr_o[9:2]][8*b +: 8] <= if2.ram_wr_data_o[8*b +: 8];
      end
    end
    r1  <= mem1[if1.ram_addr_o[9:2]];
    r2a <= mem2[if2.ram_addr_o[9:2]];
    r2b <= r2a;
  end
  assign if1.ram_rd_data_i = r1;
  assign if2.ram_rd_data_i = r2b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every CPU read response must match the oldest expected word
  always @(negedge clk) begin
    if (if1.cpu_rvalid_o) begin
      if (q1.size() == 0) chk("rvalid1_unexpected", 64'(if1.cpu_rvalid_o), 64'h0);
      else chk("rdata1", 64'(if1.cpu_rdata_o), 64'(q1.pop_front()));
    end
    if (if2.cpu_rvalid_o) begin
      if (q2.size() == 0) chk("rvalid2_unexpected", 64'(if2.cpu_rvalid_o), 64'h0);
      else chk("rdata2", 64'(if2.cpu_rdata_o), 64'(q2.pop_front()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if1.cpu_rst_n_i = 1'b1; if1.cpu_req_i = 1'b0; if1.cpu_we_i = 1'b0;
    if1.cpu_addr_i = '0; if1.cpu_be_i = '0; if1.cpu_wdata_i = '0;
    if1.dbg_sel_i = 1'b0; if1.dbg_addr_i = '0; if1.dbg_wr_byte_en_i = '0; if1.dbg_wr_data_i = '0;
    if2.cpu_rst_n_i = 1'b1; if2.cpu_req_i = 1'b0; if2.cpu_we_i = 1'b0;
    if2.cpu_addr_i = '0; if2.cpu_be_i = '0; if2.cpu_wdata_i = '0;
    if2.dbg_sel_i = 1'b0; if2.dbg_addr_i = '0; if2.dbg_wr_byte_en_i = '0; if2.dbg_wr_data_i = '0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_cpu_gnt"},  64'(if1.cpu_gnt_o),     64'h0);
    chk({p, "_rvalid"},   64'(if1.cpu_rvalid_o),  64'h0);
    chk({p, "_rdata"},    64'(if1.cpu_rdata_o),   64'h0);
    chk({p, "_dbg_gnt"},  64'(if1.dbg_gnt_o),     64'h0);
    chk({p, "_dbg_rd"},   64'(if1.dbg_rd_data_o), 64'h0);
    chk({p, "_ram_addr"}, 64'(if1.ram_addr_o),    64'h0);
    chk({p, "_ram_we"},   64'(if1.ram_wr_en_o),   64'h0);
    chk({p, "_ram_wd"},   64'(if1.ram_wr_data_o), 64'h0);
  endtask

  initial begin
    idle_inputs();
    cyc();
    chk_zero("rst");
    chk("rst_state", 64'(dut1.st_q), 64'(IDLE));
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    // CPU read burst at RD_LAT=1
    cyc(); if1.cpu_req_i = 1'b1; if1.cpu_addr_i = 32'h10;
    #1 chk("s1_idle_gnt", 64'(if1.cpu_gnt_o), 64'h0);
    cyc();
    #1 chk("s1_gnt0", 64'(if1.cpu_gnt_o), 64'h1);
    chk("s1_addr0", 64'(if1.ram_addr_o), 64'h10);
    chk("s1_we0", 64'(if1.ram_wr_en_o), 64'h0);
    chk("s1_rv0", 64'(if1.cpu_rvalid_o), 64'h0);
    q1.push_back(32'hDEADBEEF);
    cyc(); if1.cpu_addr_i = 32'h14;
    #1 chk("s1_gnt1", 64'(if1.cpu_gnt_o), 64'h1);
    chk("s1_rv1", 64'(if1.cpu_rvalid_o), 64'h1);
    q1.push_back(32'h01234567);
    cyc(); if1.cpu_req_i = 1'b0;
    #1 chk("s1_rv2", 64'(if1.cpu_rvalid_o), 64'h1);
    chk("s1_gnt2", 64'(if1.cpu_gnt_o), 64'h0);
    cyc();
    #1 chk("s1_rv3", 64'(if1.cpu_rvalid_o), 64'h0);
    cyc(); cyc();
    #1 chk("s1_idle", 64'(dut1.st_q), 64'(IDLE));
    // handover while a CPU read is in flight
    cyc(); if1.cpu_req_i = 1'b1; if1.cpu_addr_i = 32'h1C;
    #1 chk("s2_idle_gnt", 64'(if1.cpu_gnt_o), 64'h0);
    cyc();
    #1 chk("s2_gnt", 64'(if1.cpu_gnt_o), 64'h1);
    q1.push_back(32'h0BADC0DE);
    cyc(); if1.cpu_addr_i = 32'h20; if1.dbg_sel_i = 1'b1;
    #1 chk("s2_gnt_dbg", 64'(if1.cpu_gnt_o), 64'h0);
    chk("s2_rv", 64'(if1.cpu_rvalid_o), 64'h1);
    cyc();
    #1 chk("s2_drain", 64'(dut1.st_q), 64'(DRAIN));
    chk("s2_drain_dgnt", 64'(if1.dbg_gnt_o), 64'h0);
    chk("s2_drain_gnt", 64'(if1.cpu_gnt_o), 64'h0);
    // loader write then reads in DBG
    cyc(); if1.dbg_addr_i = 32'h103; if1.dbg_wr_byte_en_i = 4'b1000; if1.dbg_wr_data_i = 8'hA5;
    #1 chk("s3_dgnt", 64'(if1.dbg_gnt_o), 64'h1);
    chk("s3_gnt", 64'(if1.cpu_gnt_o), 64'h0);
    chk("s3_we", 64'(if1.ram_wr_en_o), 64'h8);
    chk("s3_addr", 64'(if1.ram_addr_o), 64'h100);
    chk("s3_wd", 64'(if1.ram_wr_data_o), 64'hA5A5A5A5);
    cyc(); if1.dbg_wr_byte_en_i = 4'b0000; if1.dbg_addr_i = 32'h102;
    #1 chk("s3_rd_we", 64'(if1.ram_wr_en_o), 64'h0);
    cyc(); if1.dbg_addr_i = 32'h103;
    #1 chk("s3_rd102", 64'(if1.dbg_rd_data_o), 64'h22);
    cyc(); if1.dbg_sel_i = 1'b0;
    #1 chk("s3_rd103", 64'(if1.dbg_rd_data_o), 64'hA5);
    chk("s3_gnt_dbg", 64'(if1.cpu_gnt_o), 64'h0);
    cyc();
    #1 chk("s3_idle_dgnt", 64'(if1.dbg_gnt_o), 64'h0);
    chk("s3_idle_gnt", 64'(if1.cpu_gnt_o), 64'h0);
    cyc();
    #1 chk("s2_regnt", 64'(if1.cpu_gnt_o), 64'h1);
    chk("s2_readdr", 64'(if1.ram_addr_o), 64'h20);
    q1.push_back(32'hCAFEF00D);
    cyc(); if1.cpu_req_i = 1'b0;
    #1 chk("s2_rerv", 64'(if1.cpu_rvalid_o), 64'h1);
    cyc(); cyc(); cyc();
    #1 chk("s2_idle", 64'(dut1.st_q), 64'(IDLE));
    // tie in IDLE: loader wins, CPU waits for it to leave
    cyc(); if1.cpu_req_i = 1'b1; if1.cpu_we_i = 1'b1; if1.cpu_addr_i = 32'h30;
    if1.cpu_be_i = 4'b0011; if1.cpu_wdata_i = 32'h12345678;
    if1.dbg_sel_i = 1'b1; if1.dbg_addr_i = '0;
    #1 chk("s4_gnt0", 64'(if1.cpu_gnt_o), 64'h0);
    cyc();
    #1 chk("s4_dgnt", 64'(if1.dbg_gnt_o), 64'h1);
    chk("s4_gnt1", 64'(if1.cpu_gnt_o), 64'h0);
    chk("s4_we_dbg", 64'(if1.ram_wr_en_o), 64'h0);
    cyc(); if1.dbg_sel_i = 1'b0;
    #1 chk("s4_gnt2", 64'(if1.cpu_gnt_o), 64'h0);
    cyc();
    #1 chk("s4_gnt3", 64'(if1.cpu_gnt_o), 64'h0);
    cyc();
    #1 chk("s4_gnt4", 64'(if1.cpu_gnt_o), 64'h1);
    chk("s4_we", 64'(if1.ram_wr_en_o), 64'h3);
    chk("s4_wd", 64'(if1.ram_wr_data_o), 64'h12345678);
    chk("s4_addr", 64'(if1.ram_addr_o), 64'h30);
    cyc(); if1.cpu_req_i = 1'b0; if1.cpu_we_i = 1'b0;
    #1 chk("s4_rv", 64'(if1.cpu_rvalid_o), 64'h0);
    // CPU held in reset with a read in flight, RD_LAT=2
    cyc(); if2.cpu_req_i = 1'b1; if2.cpu_addr_i = 32'h10;
    #1 chk("s5_idle_gnt", 64'(if2.cpu_gnt_o), 64'h0);
    cyc();
    #1 chk("s5_gnt", 64'(if2.cpu_gnt_o), 64'h1);
    cyc(); if2.cpu_req_i = 1'b0; if2.cpu_rst_n_i = 1'b0;
    #1 chk("s5_gnt_rst", 64'(if2.cpu_gnt_o), 64'h0);
    cyc(); if2.cpu_req_i = 1'b1;
    #1 chk("s5_rv0", 64'(if2.cpu_rvalid_o), 64'h0);
    chk("s5_state0", 64'(dut2.st_q), 64'(IDLE));
    chk("s5_gnt_held0", 64'(if2.cpu_gnt_o), 64'h0);
    cyc();
    #1 chk("s5_rv1", 64'(if2.cpu_rvalid_o), 64'h0);
    chk("s5_state1", 64'(dut2.st_q), 64'(IDLE));
    chk("s5_gnt_held1", 64'(if2.cpu_gnt_o), 64'h0);
    cyc(); if2.cpu_rst_n_i = 1'b1; if2.cpu_addr_i = 32'h14;
    cyc();
    #1 chk("s5_regnt", 64'(if2.cpu_gnt_o), 64'h1);
    q2.push_back(32'h01234567);
    cyc(); if2.cpu_req_i = 1'b0;
    #1 chk("s5_lat1", 64'(if2.cpu_rvalid_o), 64'h0);
    cyc();
    #1 chk("s5_lat2", 64'(if2.cpu_rvalid_o), 64'h1);
    cyc(); cyc(); cyc();
    // asynchronous reset in the middle of a CPU burst
    cyc(); if1.cpu_req_i = 1'b1; if1.cpu_addr_i = 32'h10;
    cyc();
    cyc(); if1.cpu_addr_i = 32'h14;
    #1 chk("s6_gnt", 64'(if1.cpu_gnt_o), 64'h1);
    #1 rst_n = 1'b0;
    #1 chk_zero("s6_arst");
    if1.cpu_req_i = 1'b0;
    cyc();
    chk("s6_state", 64'(dut1.st_q), 64'(IDLE));
    @(negedge clk) rst_n = 1'b1;
    cyc(); if1.cpu_req_i = 1'b1; if1.cpu_addr_i = 32'h10;
    #1 chk("s6_idle_gnt", 64'(if1.cpu_gnt_o), 64'h0);
    cyc();
    #1 chk("s6_gnt0", 64'(if1.cpu_gnt_o), 64'h1);
    q1.push_back(32'hDEADBEEF);
    cyc(); if1.cpu_addr_i = 32'h14;
    #1 chk("s6_gnt1", 64'(if1.cpu_gnt_o), 64'h1);
    chk("s6_rv1", 64'(if1.cpu_rvalid_o), 64'h1);
    q1.push_back(32'h01234567);
    cyc(); if1.cpu_req_i = 1'b0;
    #1 chk("s6_rv2", 64'(if1.cpu_rvalid_o), 64'h1);
    cyc(); cyc(); cyc();
    chk("q1_drained", 64'(q1.size()), 64'h0);
    chk("q2_drained", 64'(q2.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_port_arb.md
Name: ram_port_arb

Overview:
- Shares the single byte-enabled 32-bit system RAM port between two requesters: the CPU data bus and the UART debug loader (loader port: sel/addr/byte-enable, 8-bit read data).
- Sequences ownership with a 4-state FSM so that a port handover never happens while a CPU read is in flight.
- Realigns read data to the owning requester after the fixed RAM read latency.
- Sits between the loader, the CPU load/store unit and the RAM macro.

Parameters:
- XLEN, 32, address/data width.
- RD_LAT, 1, RAM read latency in cycles (1..4).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset; one clock, asynchronous, active-low
- cpu_rst_n_i  in  1  CPU run enable from the loader; low = CPU held in reset
- cpu_req_i  in  1  CPU access request
- cpu_we_i  in  1  CPU write (1) / read (0)
- cpu_addr_i  in  XLEN  CPU byte address
- cpu_be_i  in  4  CPU write byte enables
- cpu_wdata_i  in  XLEN  CPU write data
- cpu_gnt_o  out  1  CPU request accepted this cycle
- cpu_rvalid_o  out  1  CPU read data valid
- cpu_rdata_o  out  XLEN  CPU read data
- dbg_sel_i  in  1  loader owns/requests the port
- dbg_addr_i  in  XLEN  loader byte address
- dbg_wr_byte_en_i  in  4  loader write lane strobe (one-hot, or 0 for read)
- dbg_wr_data_i  in  8  loader write byte
- dbg_gnt_o  out  1  loader currently owns the port
- dbg_rd_data_o  out  8  loader read byte, lane-selected
- ram_addr_o  out  XLEN  RAM word address (byte address with [1:0] cleared)
- ram_wr_en_o  out  4  RAM byte write enables
- ram_wr_data_o  out  XLEN  RAM write data
- ram_rd_data_i  in  XLEN  RAM read data, RD_LAT cycles after address

Behaviour:
- Reset values:
  - state IDLE.
  - All outputs 0: cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o, dbg_gnt_o, dbg_rd_data_o, ram_addr_o, ram_wr_en_o, ram_wr_data_o.
  - Read pipeline cleared.
- States: IDLE, CPU, DRAIN, DBG.
- IDLE:
  - dbg_sel_i -> DBG (debug wins a tie).
  - Else cpu_req_i & cpu_rst_n_i -> CPU.
  - RAM outputs driven 0.
- CPU:
  - cpu_gnt_o = cpu_req_i & ~dbg_sel_i & cpu_rst_n_i, combinational.
  - On a granted access: ram_addr_o = {cpu_addr_i[XLEN-1:2],2'b00}; ram_wr_en_o = cpu_we_i ? cpu_be_i : 0; ram_wr_data_o = cpu_wdata_i.
  - A granted read pushes a 1 into an RD_LAT-deep valid shift register; cpu_rvalid_o/cpu_rdata_o are asserted exactly RD_LAT cycles after the grant.
  - One access per cycle, fully pipelined.
  - dbg_sel_i -> DRAIN.
  - ~cpu_req_i & pipeline empty -> IDLE.
- DRAIN:
  - No grants.
  - Holds until the read pipeline is empty, then -> DBG. Worst-case dwell is RD_LAT cycles.
  - If dbg_sel_i drops during DRAIN -> IDLE once empty.
- DBG:
  - dbg_gnt_o = 1.
  - ram_addr_o = {dbg_addr_i[XLEN-1:2],2'b00}; ram_wr_en_o = dbg_wr_byte_en_i; ram_wr_data_o = {4{dbg_wr_data_i}}.
  - dbg_rd_data_o = byte of ram_rd_data_i selected by dbg_addr_i[1:0], delayed through the same RD_LAT pipeline (pass-through, no valid strobe; the loader paces itself).
  - ~dbg_sel_i -> IDLE. The CPU is never granted in DBG.
- cpu_rst_n_i low while in CPU/DRAIN:
  - Immediately flush the valid pipeline; cpu_rvalid_o is 0 from the next cycle.
  - Next state is DBG if dbg_sel_i, else IDLE.
- Writes complete in the grant cycle; only reads occupy the pipeline.
- Pipeline occupancy is tracked with a counter of width $clog2(RD_LAT+1). Simultaneous push and pop leaves the count unchanged; the counter never wraps.
- Asynchronous reset mid-transfer discards in-flight reads; no rvalid is produced afterwards.

Decomposition:
- Shared package ram_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, CPU, DRAIN, DBG}.
  - Constant RAM_BE_W = 4.
- One sub-module, rd_pipe: RD_LAT-stage valid/owner/lane shift register with flush input, also providing the occupancy count.

Test Plan:
- CPU read sequence: RD_LAT=1, CPU reads 0x10, 0x14 on consecutive cycles, RAM returns 0xDEADBEEF, 0x01234567 -> cpu_rvalid_o on cycles 2 and 3 with matching data; cpu_gnt_o high both cycles.
- Handover during read: CPU read at 0x20, dbg_sel_i rises the same cycle -> cpu_gnt_o=0, state DRAIN one cycle, then dbg_gnt_o=1; the CPU read still returns valid data.
- Loader write/read: dbg_addr 0x103, byte_en 4'b1000, data 0xA5 -> ram_wr_en_o=4'b1000, ram_addr_o=0x100, ram_wr_data_o=0xA5A5A5A5. A read at 0x102 with RAM data 0x11223344 -> dbg_rd_data_o=0x22.
- Tie: dbg_sel_i and cpu_req_i rise together in IDLE -> DBG; cpu_gnt_o stays 0 until dbg_sel_i falls.
- CPU held in reset: cpu_rst_n_i falls with 1 read in flight (RD_LAT=2) -> no cpu_rvalid_o, state IDLE, cpu_gnt_o=0 while cpu_rst_n_i=0.
- Mid-burst reset: rst_n_i asserted mid-burst -> all outputs 0 asynchronously; after release, the first CPU read behaves as in scenario 1.
